// File: rtl/alu_reservation_station_if.sv
// Bundle between rename/allocate, the CDB, the ALU dispatch port and the
// reservation station; the station takes the master side of the ALU handshake.
interface alu_reservation_station_if #(
    parameter int ENTRIES   = 4,
    parameter int TAG_WIDTH = 6
);
    localparam int CW = $clog2(ENTRIES) + 1;

    logic                 flush;

    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [2:0]           alloc_op;
    logic [TAG_WIDTH-1:0] alloc_tag;
    logic                 alloc_src1_rdy;
    logic [31:0]          alloc_src1_val;
    logic [TAG_WIDTH-1:0] alloc_src1_tag;
    logic                 alloc_src2_rdy;
    logic [31:0]          alloc_src2_val;
    logic [TAG_WIDTH-1:0] alloc_src2_tag;

    logic                 cdb_valid;
    logic [TAG_WIDTH-1:0] cdb_tag;
    logic [31:0]          cdb_data;

    logic                 dispatch_valid;
    logic [2:0]           dispatch_op;
    logic [31:0]          dispatch_val1;
    logic [31:0]          dispatch_val2;
    logic [TAG_WIDTH-1:0] dispatch_tag;
    logic                 dispatch_ack;

    logic [CW-1:0]        occupancy;
    logic                 full;
    logic                 empty;

    modport master (
        input  flush,
        input  alloc_valid, alloc_op, alloc_tag,
        input  alloc_src1_rdy, alloc_src1_val, alloc_src1_tag,
        input  alloc_src2_rdy, alloc_src2_val, alloc_src2_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        input  dispatch_ack,
        output alloc_ready,
        output dispatch_valid, dispatch_op, dispatch_val1, dispatch_val2, dispatch_tag,
        output occupancy, full, empty
    );

    modport slave (
        output flush,
        output alloc_valid, alloc_op, alloc_tag,
        output alloc_src1_rdy, alloc_src1_val, alloc_src1_tag,
        output alloc_src2_rdy, alloc_src2_val, alloc_src2_tag,
        output cdb_valid, cdb_tag, cdb_data,
        output dispatch_ack,
        input  alloc_ready,
        input  dispatch_valid, dispatch_op, dispatch_val1, dispatch_val2, dispatch_tag,
        input  occupancy, full, empty
    );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: collapsing age-ordered queue with CDB wakeup,
// oldest-ready select, and same-edge shift/alloc/wakeup update.
module alu_reservation_station #(
    parameter int ENTRIES   = 4,
    parameter int TAG_WIDTH = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    alu_reservation_station_if.master  bus
);
    localparam int IW = $clog2(ENTRIES);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic                 valid;
        logic [2:0]           op;
        logic [TAG_WIDTH-1:0] tag;
        logic                 s1Rdy;
        logic [31:0]          s1Val;
        logic [TAG_WIDTH-1:0] s1Tag;
        logic                 s2Rdy;
        logic [31:0]          s2Val;
        logic [TAG_WIDTH-1:0] s2Tag;
    } entry_t;

    entry_t         r_q      [ENTRIES];
    logic [CW-1:0]  r_count;

    entry_t         w_woken  [ENTRIES];
    entry_t         w_nxt    [ENTRIES];
    entry_t         w_new;
    entry_t         w_selEntry;
    logic [CW-1:0]  w_countNxt;
    logic [CW-1:0]  w_allocIdx;
    logic [IW-1:0]  w_selIdx;
    logic           w_selFound;
    logic           w_full;
    logic           w_allocReady;
    logic           w_allocFire;
    logic           w_dispValid;
    logic           w_fire;

    // Select looks only at registered state so dispatch_valid never depends on ack.
    always_comb begin
        w_selFound = 1'b0;
        w_selIdx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (r_q[i].valid && r_q[i].s1Rdy && r_q[i].s2Rdy) begin
                w_selFound = 1'b1;
                w_selIdx   = IW'(i);
            end
        end
    end

    assign w_full       = (r_count == CW'(ENTRIES));
    assign w_allocReady = !w_full && !bus.flush;
    assign w_allocFire  = bus.alloc_valid && w_allocReady;
    assign w_dispValid  = w_selFound && !bus.flush;
    assign w_fire       = w_dispValid && bus.dispatch_ack;
    assign w_selEntry   = w_dispValid ? r_q[w_selIdx] : '0;

    assign bus.alloc_ready    = w_allocReady;
    assign bus.dispatch_valid = w_dispValid;
    assign bus.dispatch_op    = w_selEntry.op;
    assign bus.dispatch_val1  = w_selEntry.s1Val;
    assign bus.dispatch_val2  = w_selEntry.s2Val;
    assign bus.dispatch_tag   = w_selEntry.tag;
    assign bus.occupancy      = r_count;
    assign bus.full           = w_full;
    assign bus.empty          = (r_count == '0);

    // Incoming entry, with a same-cycle CDB broadcast bypassed into waiting sources.
    always_comb begin
        w_new       = '0;
        w_new.valid = 1'b1;
        w_new.op    = bus.alloc_op;
        w_new.tag   = bus.alloc_tag;
        w_new.s1Rdy = bus.alloc_src1_rdy;
        w_new.s1Val = bus.alloc_src1_val;
        w_new.s1Tag = bus.alloc_src1_tag;
        w_new.s2Rdy = bus.alloc_src2_rdy;
        w_new.s2Val = bus.alloc_src2_val;
        w_new.s2Tag = bus.alloc_src2_tag;
        if (bus.cdb_valid && !bus.alloc_src1_rdy && (bus.alloc_src1_tag == bus.cdb_tag)) begin
            w_new.s1Rdy = 1'b1;
            w_new.s1Val = bus.cdb_data;
        end
        if (bus.cdb_valid && !bus.alloc_src2_rdy && (bus.alloc_src2_tag == bus.cdb_tag)) begin
            w_new.s2Rdy = 1'b1;
            w_new.s2Val = bus.cdb_data;
        end
    end

    // Wakeup is applied before the collapse so a shifted entry keeps its capture.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_woken[i] = r_q[i];
            if (bus.cdb_valid && r_q[i].valid && !r_q[i].s1Rdy && (r_q[i].s1Tag == bus.cdb_tag)) begin
                w_woken[i].s1Rdy = 1'b1;
                w_woken[i].s1Val = bus.cdb_data;
            end
            if (bus.cdb_valid && r_q[i].valid && !r_q[i].s2Rdy && (r_q[i].s2Tag == bus.cdb_tag)) begin
                w_woken[i].s2Rdy = 1'b1;
                w_woken[i].s2Val = bus.cdb_data;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES - 1; i++) begin
            w_nxt[i] = w_woken[i];
            if (w_fire && (IW'(i) >= w_selIdx)) begin
                w_nxt[i] = w_woken[i + 1];
            end
        end
        w_nxt[ENTRIES - 1] = w_fire ? '0 : w_woken[ENTRIES - 1];

        w_allocIdx = r_count - CW'(w_fire);
        if (w_allocFire) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (CW'(i) == w_allocIdx) begin
                    w_nxt[i] = w_new;
                end
            end
        end

        w_countNxt = r_count + CW'(w_allocFire) - CW'(w_fire);

        if (bus.flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                w_nxt[i] = '0;
            end
            w_countNxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_q[i] <= w_nxt[i];
            end
            r_count <= w_countNxt;
        end
    end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Reservation station feeding one ALU execution unit: the initiator side of the ALU dispatch handshake. It holds renamed ALU ops until both source operands are available, snoops the common data bus (CDB) for operand wakeup, and issues the oldest ready op per cycle. It sits between rename/allocate and the ALU; its dispatch outputs connect directly to the ALU's dispatch inputs.

Parameters:
ENTRIES, 4, number of station entries (power of 2, >=2)
TAG_WIDTH, 6, ROB/physical tag width (matches ALU and CDB)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
flush  input  1  synchronous squash of all entries
alloc_valid  input  1  allocate request from rename
alloc_ready  output  1  station can accept an allocation
alloc_op  input  3  ALU opcode (0 ADD, 1 SUB, 4 AND, 5 OR, 6 XOR)
alloc_tag  input  TAG_WIDTH  destination tag
alloc_src1_rdy  input  1  src1 value already valid
alloc_src1_val  input  32  src1 value (used if rdy)
alloc_src1_tag  input  TAG_WIDTH  src1 producer tag (used if !rdy)
alloc_src2_rdy / alloc_src2_val / alloc_src2_tag  input  1/32/TAG_WIDTH  as src1
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  TAG_WIDTH  CDB producer tag
cdb_data  input  32  CDB result
dispatch_valid  output  1  op presented to ALU
dispatch_op  output  3  opcode
dispatch_val1  output  32  operand 1
dispatch_val2  output  32  operand 2
dispatch_tag  output  TAG_WIDTH  destination tag
dispatch_ack  input  1  ALU accepts (combinational from dispatch_valid)
occupancy  output  clog2(ENTRIES)+1  valid entry count
full  output  1  occupancy == ENTRIES
empty  output  1  occupancy == 0

Behaviour:
- Storage: collapsing age-ordered queue; index 0 oldest. Per entry: valid, op, tag, src1/src2 {rdy, val, tag}.
- Reset: all entries invalid, fields zero; occupancy=0, empty=1, full=0, alloc_ready=1, dispatch_valid=0, dispatch_op/val1/val2/tag=0.
- alloc_ready = !full && !flush. Allocation on rising edge when alloc_valid && alloc_ready; the new entry is written at position occupancy (after collapse, if a dispatch also fires).
- Alloc/CDB bypass: if cdb_valid and cdb_tag equals a non-ready alloc source tag in the allocation cycle, that source is stored rdy=1 with cdb_data.
- Wakeup: every valid entry with a non-ready source whose tag == cdb_tag while cdb_valid sets rdy=1 and val=cdb_data on the edge. Both sources may wake on the same broadcast.
- Select: the lowest-index entry with valid && src1.rdy && src2.rdy, using registered state only. dispatch_valid=1 iff such an entry exists and !flush.
  - dispatch_* show that entry's fields while dispatch_valid=1; otherwise all zero.
  - dispatch_valid never depends on dispatch_ack, so no combinational loop.
- Latency: an op allocated with both sources ready at edge N is dispatchable in cycle N+1. An op woken by CDB at edge N is dispatchable in cycle N+1.
- Handshake: dispatch_valid && dispatch_ack at an edge removes the selected entry; younger entries shift down by one. Without ack, the same entry (or an older one that became ready) is presented next cycle with no loss.
- Simultaneous alloc + dispatch: occupancy unchanged. Allocation while full is refused; there is no same-cycle free-then-alloc.
- The shift and wakeup apply in the same edge: a shifted entry keeps any wakeup captured that cycle.
- flush: on the edge, all entries are invalidated and occupancy=0. Flush wins over alloc, dispatch and wakeup. While flush=1, dispatch_valid=0 and alloc_ready=0.
- Reset mid-operation: asynchronous clear to the reset state regardless of pending handshakes.
- Tags are compared at full TAG_WIDTH equality. Values pass through unmodified (no arithmetic).

Test Plan:
- Reset -> occupancy=0, empty=1, alloc_ready=1, dispatch_valid=0, all dispatch fields 0.
- Alloc op=0 tag=5, src1=3, src2=4, both rdy, ack held 1 -> next cycle dispatch_valid=1, op=0, val1=3, val2=4, tag=5. Following cycle empty=1.
- Alloc tag=7 with src1 !rdy tag=9, src2 rdy=2. Two cycles later cdb_valid tag=9 data=0x10 -> dispatch_valid=1 the cycle after, with val1=0x10, val2=2.
- Alloc with src2 !rdy tag=12 in the same cycle as cdb_valid tag=12 data=0xAB -> dispatchable next cycle with val2=0xAB.
- Fill 4 entries with ack=0, entries 0 and 2 ready -> full=1, alloc_ready=0, extra alloc ignored. Entry 0 held stable. After ack, entry 2's data is presented, occupancy=3.
- 3 entries valid, assert flush concurrent with alloc_valid and dispatch_ack -> next cycle occupancy=0, no dispatch handshake occurred, dispatch_valid=0 during flush.
